// File: rtl/sio_pkg.sv
// Shared constants and types for the host side of the 2-bit DDR serial link.
package sio_pkg;

  localparam int         FRAME_LEN   = 128;
  localparam logic [1:0] START_SYM   = 2'b00;
  localparam logic [1:0] IDLE_SYM    = 2'b11;
  localparam int         CMD_BITS    = 20;
  localparam int         N_ADC_BYTES = 24;
  localparam int         N_RX_BYTES  = 26;
  localparam logic [3:0] NOP_ADDR    = 4'd0;

  localparam logic [3:0] ADDR_SYNC   = 4'd1;
  localparam logic [3:0] ADDR_SPI0   = 4'd2;
  localparam logic [3:0] ADDR_SPI1   = 4'd3;
  localparam logic [3:0] ADDR_STATUS = 4'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sio_deser.sv
// Packs 2-bit reply symbols into bytes (first symbol in the MSBs) and counts bytes per frame.
module sio_deser
  import sio_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       sample,
  input  logic [1:0] din,
  output logic [7:0] byte_data,
  output logic [4:0] byte_index,
  output logic       byte_valid
);

  logic [5:0] shift_r;
  logic [1:0] sym_r;
  logic [4:0] cnt_r;

  // Symbol shifter and byte counter; clear realigns both at every frame start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_r <= 6'd0;
      sym_r   <= 2'd0;
      cnt_r   <= 5'd0;
    end else if (clear) begin
      shift_r <= 6'd0;
      sym_r   <= 2'd0;
      cnt_r   <= 5'd0;
    end else if (sample) begin
      shift_r <= {shift_r[3:0], din};
      sym_r   <= sym_r + 2'd1;
      if (sym_r == 2'd3) begin
        cnt_r <= cnt_r + 5'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      shift_r <= shift_r;
      sym_r   <= sym_r;
      cnt_r   <= cnt_r;
    end
  end

  // The completed byte is presented while its fourth symbol is on din
  assign byte_data  = {shift_r, din};
  assign byte_index = cnt_r;
  assign byte_valid = sample && (sym_r == 2'd3);

endmodule

// File: rtl/sio_rx_host.sv
// Host initiator: sends start symbol plus 20-bit command each 128-clock frame, then collects the 26-byte reply.
module sio_rx_host
  import sio_pkg::*;
#(
  parameter int RX_START = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  output logic [1:0]  dout,
  output logic        oe,
  input  logic [1:0]  din,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic [7:0]  adc_data,
  output logic        adc_valid,
  output logic [4:0]  adc_index,
  output logic        adc_last,
  output logic        rsp_valid,
  output logic [3:0]  rsp_addr,
  output logic [15:0] rsp_data,
  output logic [15:0] frame_count
);

  localparam logic [6:0] FC_LAST  = 7'(FRAME_LEN - 1);
  localparam logic [6:0] RX_FIRST = 7'(RX_START);
  localparam logic [6:0] RX_LAST  = 7'(RX_START + 4 * N_RX_BYTES - 1);

  state_t              state_r;
  logic [6:0]          fc_r;
  logic [CMD_BITS-1:0] sr_r;
  logic [3:0]          addr_r;
  logic [7:0]          rsp_hi_r;
  logic                start_s;
  logic                rx_s;
  logic [7:0]          byte_data_s;
  logic [4:0]          byte_index_s;
  logic                byte_valid_s;

  assign start_s   = en && ((state_r == ST_IDLE) || (fc_r == FC_LAST));
  assign rx_s      = (state_r == ST_RUN) && (fc_r >= RX_FIRST) && (fc_r <= RX_LAST);
  assign cmd_ready = start_s;

  // Frame sequencer and command transmitter; dout/oe are registered for the value fc takes next
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      fc_r    <= 7'd0;
      sr_r    <= {CMD_BITS{1'b0}};
      addr_r  <= NOP_ADDR;
      dout    <= IDLE_SYM;
      oe      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= start_s ? ST_RUN : ST_IDLE;
          fc_r    <= 7'd0;
        end
        ST_RUN: begin
          if (fc_r == FC_LAST) begin
            state_r <= start_s ? ST_RUN : ST_IDLE;
            fc_r    <= 7'd0;
          end else begin
            state_r <= ST_RUN;
            fc_r    <= fc_r + 7'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          fc_r    <= 7'd0;
        end
      endcase

      if (start_s) begin
        sr_r   <= cmd_valid ? {cmd_addr, cmd_wdata} : {NOP_ADDR, 16'd0};
        addr_r <= cmd_valid ? cmd_addr : NOP_ADDR;
        dout   <= START_SYM;
        oe     <= 1'b1;
      end else if ((state_r == ST_RUN) && (fc_r <= 7'd9)) begin
        dout   <= sr_r[CMD_BITS-1 -: 2];
        sr_r   <= sr_r << 2;
        oe     <= 1'b1;
      end else if ((state_r == ST_RUN) && (fc_r == 7'd10)) begin
        dout   <= IDLE_SYM;
        oe     <= 1'b1;
      end else begin
        dout   <= IDLE_SYM;
        oe     <= 1'b0;
      end
    end
  end

  sio_deser u_deser (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (start_s),
    .sample     (rx_s),
    .din        (din),
    .byte_data  (byte_data_s),
    .byte_index (byte_index_s),
    .byte_valid (byte_valid_s)
  );

  // Routes completed bytes to the ADC strobe or the readback word; strobes last one clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      adc_data    <= 8'd0;
      adc_valid   <= 1'b0;
      adc_index   <= 5'd0;
      adc_last    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_addr    <= 4'd0;
      rsp_data    <= 16'd0;
      rsp_hi_r    <= 8'd0;
      frame_count <= 16'd0;
    end else begin
      adc_valid <= 1'b0;
      adc_last  <= 1'b0;
      rsp_valid <= 1'b0;
      if (byte_valid_s) begin
        if (byte_index_s < 5'(N_ADC_BYTES)) begin
          adc_valid <= 1'b1;
          adc_data  <= byte_data_s;
          adc_index <= byte_index_s;
          adc_last  <= (byte_index_s == 5'(N_ADC_BYTES - 1));
        end else if (byte_index_s == 5'(N_ADC_BYTES)) begin
          rsp_hi_r <= byte_data_s;
        end else begin
          rsp_valid   <= 1'b1;
          rsp_data    <= {rsp_hi_r, byte_data_s};
          rsp_addr    <= addr_r;
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/sio_rx_host.md
Name: sio_rx_host

Overview:
- Host-side initiator for the 2-bit-per-clock DDR serial link to the remote RX board.
- Every 128 clocks it drives a start symbol and a 20-bit command (4-bit address, 16-bit write data). It then releases the line and deserializes the 26-byte reply: 24 ADC bytes followed by a 16-bit register readback.
- Sits in the host FPGA between the command/ADC datapath and an external DDR IO cell; the IO cell is instantiated outside this block.

Parameters:
- RX_START, 15: frame cycle at which the first reply symbol is sampled on din. Absorbs target detect and IO register latency. Legal range 13..24.
- FRAME_LEN, 128: clocks per frame. Fixed by protocol; only 128 is supported.

Ports:
- clock  in  1  link clock, 31.25 MHz
- reset_n  in  1  asynchronous active-low reset
- en  in  1  allow new frames to start
- dout  out  2  symbol to pin; dout[1] is sent first half-cycle (MSB)
- oe  out  1  pin output enable
- din  in  2  symbol from pin; din[1] is the earlier bit
- cmd_valid  in  1  command pending
- cmd_ready  out  1  command accepted this cycle
- cmd_addr  in  4  target register address
- cmd_wdata  in  16  target write data
- adc_data  out  8  ADC byte
- adc_valid  out  1  adc_data strobe
- adc_index  out  5  byte index within frame, 0..23
- adc_last  out  1  high with index 23
- rsp_valid  out  1  readback strobe, once per frame
- rsp_addr  out  4  address sent in this frame
- rsp_data  out  16  readback word {byte24, byte25}
- frame_count  out  16  completed frames, wraps

Behaviour:
- Reset: all outputs 0 except dout=2'b11; frame counter fc=0; state IDLE.
- States:
  - IDLE: oe=0. Go to RUN when en=1, with fc=0.
  - RUN: fc increments each clock. At fc=127, return to IDLE if en=0, otherwise wrap to 0 and stay in RUN.
- Command latch: cmd_ready=1 only on the cycle that starts a frame (fc will become 0).
  - If cmd_valid=1 on that cycle, latch {cmd_addr, cmd_wdata} into the 20-bit sr.
  - Otherwise latch NOP (addr 0, wdata 0).
  - cmd_valid asserted mid-frame waits; it is never dropped.
- Transmit (registered outputs):
  - fc=0: oe=1, dout=2'b00 (start symbol).
  - fc=1..10: dout=sr[19:18], then sr shifts left by 2, so addr is sent MSB first, then wdata.
  - fc=11: dout=2'b11, oe=1.
  - fc>=12: oe=0, dout=2'b11.
- Receive, fc=RX_START .. RX_START+103:
  - Byte b occupies symbols 4b..4b+3, first symbol in the MSBs: byte={s0,s1,s2,s3}.
  - Bytes 0..23: on the cycle after the 4th symbol, pulse adc_valid for 1 clock with adc_index=b; adc_last=1 when b=23.
  - Bytes 24 and 25 form rsp_data. rsp_valid pulses 1 clock after byte 25 completes; rsp_addr = the address transmitted in this frame.
  - frame_count increments on the same cycle as rsp_valid.
- din is ignored outside the receive window. No adc or rsp strobes occur in IDLE.
- Readback semantics: addr 2/3 return the SPI data of the previous transaction; addr 6 returns the channel-error flag; all others echo wdata.
- en deasserted mid-frame: the current frame completes, including rsp_valid, and no new frame starts.
- Async reset mid-frame: oe drops immediately; partial bytes are discarded; no strobes are emitted.

Decomposition:
- Package sio_pkg:
  - FRAME_LEN=128, START_SYM=2'b00, IDLE_SYM=2'b11
  - CMD_BITS=20, N_ADC_BYTES=24, N_RX_BYTES=26, NOP_ADDR=4'd0
  - address constants: ADDR_SYNC=1, ADDR_SPI0=2, ADDR_SPI1=3, ADDR_STATUS=6
- Sub-module sio_deser: 2-bit symbol shifter plus byte counter. Emits byte, index and valid.

Test Plan:
- Reset, en=1, no command: fc=0 gives dout=00, oe=1; fc=1..10 all dout=00 (NOP); fc=11 dout=11; oe=0 from fc=12. Exactly one rsp_valid per 128 clocks.
- cmd addr=2, wdata=0xA55A held before the frame boundary: cmd_ready high for one cycle; symbols 1..10 = 00,10,10,10,01,01,01,01,10,10.
- Target model returns ADC bytes 0x00..0x17 and readback 0xBEEF: 24 adc_valid pulses in order with index 0..23 and adc_last on 0x17; then rsp_data=0xBEEF, rsp_addr=2.
- cmd_valid raised at fc=40: not accepted until the next frame boundary (cmd_ready at fc 127→0); the command is sent in the following frame.
- en dropped at fc=60: frame finishes and rsp_valid fires; oe stays 0 afterwards; frame_count stops.
- reset_n asserted at fc=70: oe=0 and dout=11 in the same cycle; no adc_valid or rsp_valid. After release with en=1, a clean frame starts and frame_count=1 after it.
